gray_row_streamer: RTL and testbench
====================================

// Module: gray_row_streamer
// PURPOSE
//  Row-to-pixel serializer sitting directly downstream of the grayscale stage.
//  Accepts one packed row of COL grayscale pixels per handshake and emits them
//  one pixel per cycle on a valid/ready stream with SOL/EOL/SOF/EOF markers,
//  feeding pixel-serial consumers (line buffers, filters, output DMA).
// PARAMETERS
//  COL    256  pixels per row
//  ROW    256  rows per frame
//  WIDTH  8    bits per grayscale pixel
// PORTS
//  clk         in   1          single clock; all state updates on posedge
//  rst         in   1          asynchronous, active-low reset
//  row_in      in   COL*WIDTH  packed row; pixel i = row_in[WIDTH*i +: WIDTH]
//  row_valid   in   1          row_in valid
//  row_sof     in   1          row_in is first row of a frame (qualified by row_valid)
//  row_ready   out  1          block can accept a row this cycle
//  pix_data    out  WIDTH      current pixel
//  pix_valid   out  1          pix_data valid
//  pix_ready   in   1          downstream accepts pixel
//  pix_sol     out  1          pixel is column 0
//  pix_eol     out  1          pixel is column COL-1
//  pix_sof     out  1          pixel is row 0, column 0
//  pix_eof     out  1          pixel is row ROW-1, column COL-1
//  frame_done  out  1          one-cycle pulse after EOF pixel transfers
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, row buffer 0, col_cnt 0, row_cnt 0,
//    pix_valid 0, pix_data 0, all markers 0, frame_done 0. In-flight row dropped.
//  - States: IDLE, STREAM. pix_valid = (state==STREAM), registered.
//  - row accept: row_valid && row_ready. row_ready = (state==IDLE) ||
//    (state==STREAM && pix_ready && col_cnt==COL-1) (back-to-back rows).
//  - On accept: buffer <= row_in, col_cnt <= 0, state <= STREAM; row_cnt <= 0
//    if row_sof, else row_cnt unchanged (already advanced). Pixel 0 appears with
//    pix_valid=1 in the cycle after the accepting edge (latency 1).
//  - pix_data = buffer[WIDTH-1:0]. Pixel transfer: pix_valid && pix_ready ->
//    buffer shifts right by WIDTH (zeros in), col_cnt+1.
//  - Stall (pix_valid && !pix_ready): data, markers, counters held stable.
//  - Last pixel (col_cnt==COL-1) transfer: row_cnt <= (row_cnt==ROW-1) ? 0 :
//    row_cnt+1; if row_valid same cycle, new row loaded (stay STREAM, no bubble,
//    row_sof applies); else state <= IDLE, pix_valid 0, pix_data 0.
//  - Markers combinational from counters, gated by pix_valid: sol=(col==0),
//    eol=(col==COL-1), sof=sol&&(row==0), eof=eol&&(row==ROW-1).
//  - frame_done: registered, high for exactly the cycle after EOF transfer.
//  - row_sof on a row with row_cnt!=0 resynchronises (row_cnt forced 0); no error.
//  - row_valid while row_ready=0: ignored, upstream must hold row_in.
//  - Reset mid-row: outputs return to reset values immediately; next accepted
//    row numbered 0 regardless of row_sof.
// TESTING
//  1 reset, row_in pixel i = i, row_valid 1 cycle, pix_ready=1 -> pix_data 0..255
//    on 256 consecutive cycles, sol on 0, eol on 255, sof on first, state IDLE after.
//  2 pix_ready toggled 1/0 pseudo-randomly -> same 0..255 sequence, values and
//    markers stable during stalls, no pixel lost or duplicated.
//  3 row_valid held high with new row each accept, pix_ready=1 -> 256*256 pixels
//    no bubbles, eof on last, frame_done pulse 1 cycle later, next sof at row 0.
//  4 row_sof asserted on row 5 of a frame -> that row's first pixel has pix_sof=1.
//  5 rst low at column 100 -> pix_valid 0, row_ready 1 same cycle; next row
//    streams from column 0 with pix_sof=1.
//  6 row_valid while streaming column 50 -> row_ready 0, ignored; accepted only
//    on column 255 transfer cycle.

Source files
------------

// File: rtl/gray_row_streamer_if.sv
// Row-in / pixel-out stream bundle for the grayscale row serializer.
// master = upstream row producer plus downstream pixel consumer; slave = the streamer.
interface gray_row_streamer_if #(
  parameter int COL   = 256,
  parameter int WIDTH = 8
);
  logic [COL*WIDTH-1:0] row_in;
  logic                 row_valid;
  logic                 row_sof;
  logic                 row_ready;
  logic [WIDTH-1:0]     pix_data;
  logic                 pix_valid;
  logic                 pix_ready;
  logic                 pix_sol;
  logic                 pix_eol;
  logic                 pix_sof;
  logic                 pix_eof;
  logic                 frame_done;

  modport master (
    output row_in, row_valid, row_sof, pix_ready,
    input  row_ready, pix_data, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof, frame_done
  );

  modport slave (
    input  row_in, row_valid, row_sof, pix_ready,
    output row_ready, pix_data, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof, frame_done
  );
endinterface

// File: rtl/gray_row_streamer.sv
// Serializes one packed grayscale row per handshake into a pixel stream with
// SOL/EOL/SOF/EOF markers and a frame_done pulse after the last pixel of a frame.
module gray_row_streamer #(
  parameter int COL   = 256,
  parameter int ROW   = 256,
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  gray_row_streamer_if.slave  bus
);

  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int BW = COL * WIDTH;
  localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   row_buf_p0, row_buf_nx;
  logic [CW-1:0]   col_cnt, col_nx;
  logic [RW-1:0]   row_cnt, row_nx;
  logic            done_p0, done_nx;
  logic            vld_p0;
  logic            xfer;
  logic            last_xfer;
  logic            row_ready_c;
  logic            accept;

  assign vld_p0      = (state == STREAM);
  assign xfer        = vld_p0 && bus.pix_ready;
  assign last_xfer   = xfer && (col_cnt == COL_LAST);
  // Accepting on the last-pixel transfer lets rows run back to back without a bubble.
  assign row_ready_c = (state == IDLE) || last_xfer;
  assign accept      = bus.row_valid && row_ready_c;

  always_comb begin
    state_nx   = state;
    row_buf_nx = row_buf_p0;
    col_nx     = col_cnt;
    row_nx     = row_cnt;
    done_nx    = 1'b0;
    if (xfer) begin
      row_buf_nx = row_buf_p0 >> WIDTH;
      col_nx     = col_cnt + 1'b1;
    end
    if (last_xfer) begin
      row_nx   = (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
      done_nx  = (row_cnt == ROW_LAST);
      col_nx   = '0;
      state_nx = IDLE;
    end
    // A new row overrides the drain; row_sof resynchronises the row counter.
    if (accept) begin
      row_buf_nx = bus.row_in;
      col_nx     = '0;
      state_nx   = STREAM;
      if (bus.row_sof) row_nx = '0;
    end
  end

  // Stage p0: row buffer, counters and FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      row_buf_p0 <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      done_p0    <= 1'b0;
    end else begin
      state      <= state_nx;
      row_buf_p0 <= row_buf_nx;
      col_cnt    <= col_nx;
      row_cnt    <= row_nx;
      done_p0    <= done_nx;
    end
  end

  // The buffer drains to zero on the final shift, so pix_data idles at 0.
  assign bus.pix_data   = row_buf_p0[WIDTH-1:0];
  assign bus.pix_valid  = vld_p0;
  assign bus.row_ready  = row_ready_c;
  assign bus.pix_sol    = vld_p0 && (col_cnt == '0);
  assign bus.pix_eol    = vld_p0 && (col_cnt == COL_LAST);
  assign bus.pix_sof    = vld_p0 && (col_cnt == '0) && (row_cnt == '0);
  assign bus.pix_eof    = vld_p0 && (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
  assign bus.frame_done = done_p0;

endmodule

// File: tb/tb_gray_row_streamer.sv
// Directed bench for gray_row_streamer: single rows, stalls, back-to-back frames,
// row_sof resync, mid-row reset and row_valid held while streaming.
module tb_gray_row_streamer;

  localparam int COL   = 256;
  localparam int ROW   = 16;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mrow    = 0;
  bit   exp_fd  = 1'b0;
  int   cur_col = -1;

  gray_row_streamer_if #(.COL(COL), .WIDTH(WIDTH)) bus ();

  gray_row_streamer #(.COL(COL), .ROW(ROW), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [COL*WIDTH-1:0] mk_row(input int base);
    logic [COL*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) r[WIDTH*i +: WIDTH] = WIDTH'(base + i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s col=%0d observed=%0h expected=%0h", tag, cur_col, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    bus.row_valid = 1'b0;
    bus.row_sof   = 1'b0;
    cur_col = -1;
    #1;
    chk({tag, ".pix_valid"},  32'(bus.pix_valid),  0);
    chk({tag, ".pix_data"},   32'(bus.pix_data),   0);
    chk({tag, ".markers"},    32'({bus.pix_sol, bus.pix_eol, bus.pix_sof, bus.pix_eof}), 0);
    chk({tag, ".row_ready"},  32'(bus.row_ready),  1);
    chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(exp_fd));
    @(posedge clk);
    exp_fd = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_row(input int base, input bit sof);
    bus.row_in    = mk_row(base);
    bus.row_valid = 1'b1;
    bus.row_sof   = sof;
    bus.pix_ready = 1'b1;
    cur_col = -1;
    #1;
    chk("start.row_ready",  32'(bus.row_ready),  1);
    chk("start.pix_valid",  32'(bus.pix_valid),  0);
    chk("start.frame_done", 32'(bus.frame_done), 32'(exp_fd));
    @(posedge clk);
    if (sof) mrow = 0;
    exp_fd = 1'b0;
    @(negedge clk);
    bus.row_valid = 1'b0;
    bus.row_sof   = 1'b0;
  endtask

  // Checks one row column by column; row_valid with the next row rises at rv_from.
  task automatic stream_row(input int base, input bit stall, input int rv_from,
                            input int nbase, input bit nsof, input int stop_at);
    int  c = 0;
    int  stalls = 0;
    bit  pr;
    while (c < COL) begin
      if (c == stop_at) return;
      pr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalls >= 3) pr = 1'b1;
      bus.pix_ready = pr;
      if (c >= rv_from) begin
        bus.row_in    = mk_row(nbase);
        bus.row_valid = 1'b1;
        bus.row_sof   = nsof;
      end
      cur_col = c;
      #1;
      chk("pix_valid",  32'(bus.pix_valid),  1);
      chk("pix_data",   32'(bus.pix_data),   32'((base + c) & 255));
      chk("pix_sol",    32'(bus.pix_sol),    32'(c == 0));
      chk("pix_eol",    32'(bus.pix_eol),    32'(c == COL - 1));
      chk("pix_sof",    32'(bus.pix_sof),    32'(c == 0 && mrow == 0));
      chk("pix_eof",    32'(bus.pix_eof),    32'(c == COL - 1 && mrow == ROW - 1));
      chk("frame_done", 32'(bus.frame_done), 32'(exp_fd));
      chk("row_ready",  32'(bus.row_ready),  32'(pr && c == COL - 1));
      @(posedge clk);
      exp_fd = pr && (c == COL - 1) && (mrow == ROW - 1);
      if (pr) begin
        if (c == COL - 1) begin
          mrow = (mrow == ROW - 1) ? 0 : mrow + 1;
          if (c >= rv_from && nsof) mrow = 0;
        end
        c++;
        stalls = 0;
      end else begin
        stalls++;
      end
      @(negedge clk);
    end
    bus.row_valid = 1'b0;
    bus.row_sof   = 1'b0;
  endtask

  initial begin
    bus.row_in    = '0;
    bus.row_valid = 1'b0;
    bus.row_sof   = 1'b0;
    bus.pix_ready = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b1;

    // Single row, continuous ready
    start_row(0, 1'b1);
    stream_row(0, 1'b0, COL, 0, 1'b0, COL);
    check_idle("t1.idle");

    // Single row with pseudo-random stalls
    start_row(3, 1'b0);
    stream_row(3, 1'b1, COL, 0, 1'b0, COL);
    check_idle("t2.idle");

    // Full frame back to back, wrap into next frame, then row_sof on row 5
    start_row(0, 1'b1);
    for (int k = 0; k < ROW + 6; k++) begin
      if (k == ROW + 5)
        stream_row(k * 7, 1'b0, COL, 0, 1'b0, COL);
      else
        stream_row(k * 7, 1'b0, COL - 1, (k + 1) * 7, (k + 1 == ROW + 5), COL);
    end
    check_idle("t4.idle");

    // Reset at column 100
    start_row(8'h40, 1'b0);
    stream_row(8'h40, 1'b0, COL, 0, 1'b0, 100);
    rst = 1'b0;
    cur_col = 100;
    #1;
    chk("t5.rst.pix_valid", 32'(bus.pix_valid), 0);
    chk("t5.rst.row_ready", 32'(bus.row_ready), 1);
    chk("t5.rst.pix_data",  32'(bus.pix_data),  0);
    chk("t5.rst.markers",   32'({bus.pix_sol, bus.pix_eol, bus.pix_sof, bus.pix_eof}), 0);
    mrow   = 0;
    exp_fd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("t5.held");
    rst = 1'b1;
    start_row(8'h55, 1'b0);
    stream_row(8'h55, 1'b0, COL, 0, 1'b0, COL);
    check_idle("t5.idle");

    // row_valid raised at column 50, accepted only on the last transfer
    start_row(8'h20, 1'b1);
    stream_row(8'h20, 1'b0, 50, 8'h90, 1'b0, COL);
    stream_row(8'h90, 1'b0, COL, 0, 1'b0, COL);
    check_idle("t6.idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
